la_capture_sequencer: RTL and testbench

//  Sequences one triggered acquisition of the 4-channel logic-analyzer inputs into an external DEPTH-entry sample buffer.

---
 rtl/la_capture_sequencer_pkg.sv | 30 +++
 rtl/la_capture_sequencer_trigger_match.sv | 48 ++++
 rtl/la_capture_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_la_capture_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_capture_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// la_capture_sequencer_pkg
//   Definitions shared by the logic-analyzer capture blocks: channel width,
//   default buffer depth and divider width, the sequencer state encoding
//   (also visible to the output mux through the 'state' port), and the
//   masked channel compare used by the trigger.
// ---------------------------------------------------------------------------
package la_capture_sequencer_pkg;

  localparam int LA_CH_W      = 4;
  localparam int LA_DEPTH_DEF = 16;
  localparam int LA_DIVW_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_READ = 3'd4
  } la_state_t;

  // Channels outside the mask always compare equal, so a zero mask matches
  // every sample.
  function automatic logic la_match(input logic [LA_CH_W-1:0] ch,
                                    input logic [LA_CH_W-1:0] mask,
                                    input logic [LA_CH_W-1:0] val);
    return ((ch & mask) == (val & mask));
  endfunction

endpackage

// File: rtl/la_capture_sequencer_trigger_match.sv
// ---------------------------------------------------------------------------
// la_trigger_match
//   Masked compare of the current sample against the trigger value, with an
//   optional rising-edge qualifier.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     start      acquisition start; primes prev_match to 1
//     tick       sample tick during PRE/WAIT; updates prev_match
//     ch         current channel sample (the one being ticked)
//     cfg_mask   trigger channel mask (latched copy)
//     cfg_val    trigger compare value (latched copy)
//     cfg_edge   1 = rising edge of match, 0 = match level
//     trig       tick-qualified trigger
// ---------------------------------------------------------------------------
module la_trigger_match
  import la_capture_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [LA_CH_W-1:0] ch,
  input  logic [LA_CH_W-1:0] cfg_mask,
  input  logic [LA_CH_W-1:0] cfg_val,
  input  logic               cfg_edge,
  output logic               trig
);

  logic match;
  logic prev_match;

  assign match = la_match(ch, cfg_mask, cfg_val);

  // prev_match starts at 1 so a level that already matches when the
  // acquisition begins never counts as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_match <= 1'b1;
    end else if (start) begin
      prev_match <= 1'b1;
    end else if (tick) begin
      prev_match <= match;
    end
  end

  assign trig = tick & (cfg_edge ? (match & ~prev_match) : match);

endmodule

// File: rtl/la_capture_sequencer.sv
// ---------------------------------------------------------------------------
// la_capture_sequencer
//   Runs one triggered acquisition of the 4 channel inputs into an external
//   DEPTH-entry buffer (pre-trigger fill, trigger wait, post-trigger capture)
//   then reads the whole buffer out oldest-first.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     arm           start request, rising edge honoured in IDLE only
//     abort         level, forces IDLE (highest priority)
//     ch_in         synchronised channel inputs
//     cfg_*         trigger mask/value/edge, pre-trigger count, divider
//                   (all latched at start)
//     buf_we/waddr/wdata  buffer write port, registered
//     rd_valid/rd_ready/rd_addr  readout address stream
//     trig_pos      buffer address of the trigger sample
//     state         FSM state (IDLE=0 PRE=1 WAIT=2 POST=3 READ=4)
//     done          one-cycle pulse after the last readout handshake
//
//   Readout handshake: rd_addr is presented with rd_valid high for the whole
//   READ phase; a transfer happens on every clock edge where rd_valid and
//   rd_ready are both high, and rd_addr only moves on such a transfer, so it
//   is stable while rd_ready is low. The buffer is read combinationally at
//   rd_addr by the consumer.
// ---------------------------------------------------------------------------
module la_capture_sequencer
  import la_capture_sequencer_pkg::*;
#(
  parameter int DEPTH = LA_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int DIVW  = LA_DIVW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic [LA_CH_W-1:0] ch_in,
  input  logic [LA_CH_W-1:0] cfg_mask,
  input  logic [LA_CH_W-1:0] cfg_val,
  input  logic               cfg_edge,
  input  logic [AW-1:0]      cfg_pretrig,
  input  logic [DIVW-1:0]    cfg_div,
  output logic               buf_we,
  output logic [AW-1:0]      buf_waddr,
  output logic [LA_CH_W-1:0] buf_wdata,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [AW-1:0]      rd_addr,
  output logic [AW-1:0]      trig_pos,
  output logic [2:0]         state,
  output logic               done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  la_state_t state_q, state_d;

  logic               arm_q;
  logic [LA_CH_W-1:0] mask_q;
  logic [LA_CH_W-1:0] val_q;
  logic               edge_q;
  logic [AW-1:0]      pretrig_q;
  logic [DIVW-1:0]    div_q;
  logic [DIVW-1:0]    div_cnt;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      post_cnt;
  logic [AW-1:0]      rd_cnt;

  logic          start;
  logic          active;
  logic          tick;
  logic          eval_tick;
  logic          trig;
  logic          trig_hit;
  logic          hs;
  logic          last_hs;
  logic          enter_read;
  logic [AW-1:0] pre_last;
  logic [AW-1:0] post_load;

  // Abort beats a simultaneous start edge.
  assign start     = arm & ~arm_q & (state_q == ST_IDLE) & ~abort;
  assign active    = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign tick      = active && (div_cnt == div_q);
  assign eval_tick = tick && ((state_q == ST_PRE) || (state_q == ST_WAIT));
  assign trig_hit  = trig && (state_q == ST_WAIT);

  // The pre-trigger count is AW bits wide, so it can never exceed DEPTH-1;
  // the clamp is implicit in the port width.
  assign pre_last  = pretrig_q - AW'(1);
  assign post_load = LAST_IDX - pretrig_q;

  assign rd_valid   = (state_q == ST_READ);
  assign hs         = rd_valid & rd_ready;
  assign last_hs    = hs && (rd_cnt == LAST_IDX);
  assign enter_read = (state_d == ST_READ) && (state_q != ST_READ);

  assign state = state_q;

  la_trigger_match u_trig (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tick     (eval_tick),
    .ch       (ch_in),
    .cfg_mask (mask_q),
    .cfg_val  (val_q),
    .cfg_edge (edge_q),
    .trig     (trig)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (cfg_pretrig == '0) ? ST_WAIT : ST_PRE;
      // wptr counts PRE samples from 0, so the last PRE tick is at pretrig-1.
      ST_PRE:  if (tick && (wptr == pre_last)) state_d = ST_WAIT;
      ST_WAIT: if (trig_hit) state_d = (post_load == '0) ? ST_READ : ST_POST;
      // The final post write's strobe lands in the first READ cycle; the
      // readout starts at the oldest entry, which is not that one.
      ST_POST: if (tick && (post_cnt == AW'(1))) state_d = ST_READ;
      ST_READ: if (last_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q     <= 1'b0;
      mask_q    <= '0;
      val_q     <= '0;
      edge_q    <= 1'b0;
      pretrig_q <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
      wptr      <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      rd_addr   <= '0;
      trig_pos  <= '0;
      done      <= 1'b0;
    end else begin
      arm_q  <= arm;
      buf_we <= tick & ~abort;
      done   <= last_hs & ~abort;

      if (active && !tick) begin
        div_cnt <= div_cnt + DIVW'(1);
      end else begin
        div_cnt <= '0;
      end

      if (tick) begin
        buf_wdata <= ch_in;
        buf_waddr <= wptr;
        wptr      <= wptr + AW'(1);
      end

      if (start) begin
        mask_q    <= cfg_mask;
        val_q     <= cfg_val;
        edge_q    <= cfg_edge;
        pretrig_q <= cfg_pretrig;
        div_q     <= cfg_div;
        wptr      <= '0;
      end

      if (trig_hit) begin
        trig_pos <= wptr;
        post_cnt <= post_load;
      end else if ((state_q == ST_POST) && tick) begin
        post_cnt <= post_cnt - AW'(1);
      end

      // Oldest sample sits pretrig entries before the trigger. When READ is
      // entered straight from WAIT, trig_pos is only being written this
      // cycle, so the trigger address comes from wptr.
      if (enter_read) begin
        rd_addr <= ((state_q == ST_WAIT) ? wptr : trig_pos) - pretrig_q;
        rd_cnt  <= '0;
      end else if (hs) begin
        rd_addr <= rd_addr + AW'(1);
        rd_cnt  <= rd_cnt + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_la_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_la_capture_sequencer
//   Directed bench for la_capture_sequencer (DEPTH=16, DIVW=8): reset,
//   level and edge triggers, divider spacing, readout with backpressure,
//   abort, ignored arm edges and asynchronous reset mid-capture.
// ---------------------------------------------------------------------------
module tb_la_capture_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] ch_in = '0;
  logic [3:0] cfg_mask = '0;
  logic [3:0] cfg_val = '0;
  logic       cfg_edge = 1'b0;
  logic [3:0] cfg_pretrig = '0;
  logic [7:0] cfg_div = '0;
  logic       rd_ready = 1'b0;

  logic       buf_we;
  logic [3:0] buf_waddr;
  logic [3:0] buf_wdata;
  logic       rd_valid;
  logic [3:0] rd_addr;
  logic [3:0] trig_pos;
  logic [2:0] state;
  logic       done;

  la_capture_sequencer #(.DEPTH(16), .AW(4), .DIVW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .ch_in       (ch_in),
    .cfg_mask    (cfg_mask),
    .cfg_val     (cfg_val),
    .cfg_edge    (cfg_edge),
    .cfg_pretrig (cfg_pretrig),
    .cfg_div     (cfg_div),
    .buf_we      (buf_we),
    .buf_waddr   (buf_waddr),
    .buf_wdata   (buf_wdata),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .trig_pos    (trig_pos),
    .state       (state),
    .done        (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  logic [3:0] mem [16];
  logic [3:0] exp_q [$];

  // External buffer model and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (buf_we) begin
      mem[buf_waddr] = buf_wdata;
      we_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_capture(input logic [3:0] mask, input logic [3:0] val,
                               input logic edg, input logic [3:0] pre, input logic [7:0] div);
    cfg_mask    = mask;
    cfg_val     = val;
    cfg_edge    = edg;
    cfg_pretrig = pre;
    cfg_div     = div;
    arm         = 1'b1;
    @(posedge clk);
  endtask

  // Drop arm and disturb the config right after start; the DUT must use the
  // values seen at the start edge.
  task automatic scramble_cfg();
    arm         = 1'b0;
    cfg_mask    = ~cfg_mask;
    cfg_val     = ~cfg_val;
    cfg_edge    = ~cfg_edge;
    cfg_pretrig = cfg_pretrig + 4'd3;
    cfg_div     = cfg_div + 8'd5;
  endtask

  function automatic logic [3:0] level_val(input int k);
    return (k == 9) ? 4'hA : 4'(k);
  endfunction

  function automatic logic [3:0] edge_val(input int k);
    if (k < 20) return 4'hA;
    if (k == 20) return 4'h0;
    if (k == 21) return 4'hA;
    return 4'(k);
  endfunction

  function automatic logic [3:0] exp_data(input logic [3:0] a, input logic [3:0] t);
    return (a == t) ? 4'hA : a;
  endfunction

  // Readout of 16 entries from 'first'; called with the DUT already in READ.
  task automatic readout(input logic [3:0] first, input bit rand_ready,
                         input bit chk_data, input logic [3:0] taddr);
    int guard;
    logic [3:0] a;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      a = first + 4'(i);
      exp_q.push_back(a);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("rd_valid", rd_valid, 1);
      check_eq("rd_addr", rd_addr, exp_q[0]);
      if (rd_ready) begin
        if (chk_data) check_eq("rd_data", mem[rd_addr], exp_data(exp_q[0], taddr));
        void'(exp_q.pop_front());
      end
      step();
      guard++;
    end
    rd_ready = 1'b0;
    check_eq("hs_count", 16 - exp_q.size(), 16);
    check_eq("done_pulse", done, 1);
    check_eq("rd_valid_end", rd_valid, 0);
    check_eq("state_end", state, 0);
    step();
    check_eq("done_cleared", done, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0, w0, w10, last, wcnt;
    bit found, saw_post;

    // Reset held
    repeat (3) @(posedge clk);
    step();
    check_eq("rst_state", state, 0);
    check_eq("rst_buf_we", buf_we, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_trig_pos", trig_pos, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    step();
    check_eq("idle_after_rst", state, 0);

    // Level trigger: pretrig 4, div 0, 0xA at sample 9
    d0 = done_cnt;
    w0 = we_cnt;
    w10 = 0;
    start_capture(4'hF, 4'hA, 1'b0, 4'd4, 8'd0);
    for (int k = 0; k <= 20; k++) begin
      step();
      if (k == 0) scramble_cfg();
      if (k == 2) check_eq("lvl_pre", state, 1);
      if (k == 4) check_eq("lvl_wait", state, 2);
      if (k == 10) begin
        check_eq("lvl_post", state, 3);
        check_eq("lvl_trig_pos", trig_pos, 9);
        w10 = we_cnt;
      end
      ch_in = level_val(k);
    end
    step();
    check_eq("lvl_read", state, 4);
    check_eq("lvl_total_writes", we_cnt - w0, 21);
    check_eq("lvl_post_writes", we_cnt - w10, 11);
    readout(4'd5, 1'b0, 1'b1, 4'd9);
    check_eq("lvl_done_count", done_cnt - d0, 1);

    // Abort in WAIT; edge mode with zero mask never triggers
    step();
    start_capture(4'h0, 4'h0, 1'b1, 4'd0, 8'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) scramble_cfg();
      ch_in = 4'(k);
    end
    check_eq("edge_mask0_wait", state, 2);
    abort = 1'b1;
    step();
    check_eq("abort_wait_state", state, 0);
    check_eq("abort_wait_we", buf_we, 0);
    abort = 1'b0;
    step();

    // Asynchronous reset mid-cycle during WAIT
    start_capture(4'h0, 4'h0, 1'b1, 4'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) scramble_cfg();
      ch_in = 4'(k + 3);
    end
    #2 rst = 1'b1;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_buf_we", buf_we, 0);
    check_eq("arst_waddr", buf_waddr, 0);
    check_eq("arst_wdata", buf_wdata, 0);
    check_eq("arst_trig_pos", trig_pos, 0);
    check_eq("arst_rd_valid", rd_valid, 0);
    step();
    rst = 1'b0;
    step();

    // Divider 3, pretrig 15: a write every 4 clocks, READ right after trigger
    d0 = done_cnt;
    last = -1;
    wcnt = 0;
    found = 1'b0;
    saw_post = 1'b0;
    start_capture(4'h0, 4'h0, 1'b0, 4'd15, 8'd3);
    for (int n = 0; n < 100; n++) begin
      step();
      if (n == 0) scramble_cfg();
      ch_in = 4'(n);
      if (state == 3'd3) saw_post = 1'b1;
      if (buf_we) begin
        if (last >= 0) check_eq("div_spacing", n - last, 4);
        last = n;
        wcnt++;
      end
      if (state == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("div_read_reached", found, 1);
    check_eq("div_no_post", saw_post, 0);
    check_eq("div_writes", wcnt, 16);
    check_eq("div_read_with_we", buf_we, 1);
    check_eq("div_trig_pos", trig_pos, 15);
    readout(4'd0, 1'b0, 1'b0, 4'd0);
    check_eq("div_done_count", done_cnt - d0, 1);

    // Zero mask level trigger, arm edge in POST ignored, abort in READ
    step();
    start_capture(4'h0, 4'h0, 1'b0, 4'd0, 8'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) scramble_cfg();
      if (k == 1) begin
        check_eq("mask0_post", state, 3);
        check_eq("mask0_trig_pos", trig_pos, 0);
      end
      if (k == 5) arm = 1'b1;
      if (k == 6) begin
        check_eq("arm_in_post", state, 3);
        arm = 1'b0;
      end
      ch_in = 4'(k);
    end
    step();
    check_eq("post_to_read", state, 4);
    d0 = done_cnt;
    rd_ready = 1'b1;
    step();
    step();
    step();
    check_eq("rd_addr_after3", rd_addr, 3);
    rd_ready = 1'b0;
    abort = 1'b1;
    step();
    check_eq("abort_read_state", state, 0);
    check_eq("abort_read_valid", rd_valid, 0);
    abort = 1'b0;
    repeat (5) step();
    check_eq("abort_no_done", done_cnt - d0, 0);

    // Abort and arm edge together
    abort = 1'b1;
    arm = 1'b1;
    step();
    check_eq("abort_arm_state", state, 0);
    abort = 1'b0;
    step();
    check_eq("arm_after_abort", state, 0);
    arm = 1'b0;
    step();

    // Edge trigger on return to 0xA, readout under random backpressure
    d0 = done_cnt;
    ch_in = 4'hA;
    start_capture(4'hF, 4'hA, 1'b1, 4'd0, 8'd0);
    for (int k = 0; k <= 36; k++) begin
      step();
      if (k == 0) scramble_cfg();
      if (k == 21) check_eq("edge_hold_no_trig", state, 2);
      if (k == 22) begin
        check_eq("edge_post", state, 3);
        check_eq("edge_trig_pos", trig_pos, 5);
      end
      ch_in = edge_val(k);
    end
    step();
    check_eq("edge_read", state, 4);
    readout(4'd5, 1'b1, 1'b1, 4'd5);
    check_eq("edge_done_count", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
